// File: rtl/program_loader.sv
// Purpose: receives a length-prefixed, XOR-checksummed byte stream and writes it into instruction memory.
// Latency: one write cycle after each word's low byte; DONE/ERROR is entered on the edge that takes the closing byte.
// Backpressure: byte_ready_out is low outside the byte-accepting states, so bytes offered during WRITE are held by the sender.
module program_loader #(
    parameter int DATA_WIDTH        = 11,
    parameter int INSTRUCTION_WIDTH = 15,
    parameter int ADDR_WIDTH        = 11
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         start_in,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid_in,
    output logic                         byte_ready_out,
    output logic                         imem_wr_out,
    output logic [ADDR_WIDTH-1:0]        imem_addr_out,
    output logic [INSTRUCTION_WIDTH:0]   imem_data_out,
    output logic                         cpu_reset_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic [1:0]                   error_out,
    output logic [ADDR_WIDTH:0]          word_count_out
);
    // Opcode occupies the top bits of the word, i.e. the top bits of the high byte.
    localparam int OPC_W = INSTRUCTION_WIDTH + 1 - DATA_WIDTH;
    localparam logic [OPC_W-1:0] MAX_OPC = OPC_W'(14);
    localparam logic [16:0] MAX_N = 17'(1) << ADDR_WIDTH;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_OPC  = 2'b10;
    localparam logic [1:0] ERR_SUM  = 2'b11;

    typedef enum logic [3:0] {
        IDLE, LEN_H, LEN_L, WORD_H, WORD_L, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [7:0]             hi_q, hi_d;
    logic [7:0]             lo_q, lo_d;
    logic [7:0]             csum_q, csum_d;
    logic [1:0]             err_q, err_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH:0]    wcount_q, wcount_d;

    logic                   xfer;
    logic [15:0]            n_rx;

    assign byte_ready_out = (state_q == LEN_H) || (state_q == LEN_L) || (state_q == WORD_H) ||
                            (state_q == WORD_L) || (state_q == CHECK);
    assign xfer           = byte_valid_in && byte_ready_out;
    assign n_rx           = {len_q[15:8], byte_in};

    assign imem_wr_out    = (state_q == WRITE);
    assign imem_addr_out  = addr_q;
    assign imem_data_out  = (state_q == WRITE) ? (INSTRUCTION_WIDTH+1)'({hi_q, lo_q})
                                               : '0;
    assign done_out       = (state_q == DONE);
    assign cpu_reset_out  = (state_q == DONE);
    assign busy_out       = byte_ready_out || (state_q == WRITE);
    assign error_out      = err_q;
    assign word_count_out = wcount_q;

    // State and datapath registers; reset wins over everything, including a live session.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            len_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            csum_q   <= '0;
            err_q    <= ERR_NONE;
            addr_q   <= '0;
            wcount_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            csum_q   <= csum_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wcount_q <= wcount_d;
        end
    end

    // Next-state logic: header parse, per-word opcode screen, write strobe, checksum verdict.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        csum_d   = csum_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wcount_d = wcount_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_in) begin
                    state_d  = LEN_H;
                    csum_d   = '0;
                    err_d    = ERR_NONE;
                    addr_d   = '0;
                    wcount_d = '0;
                end
            end
            LEN_H: begin
                if (xfer) begin
                    len_d   = {byte_in, len_q[7:0]};
                    csum_d  = csum_q ^ byte_in;
                    state_d = LEN_L;
                end
            end
            LEN_L: begin
                if (xfer) begin
                    len_d  = n_rx;
                    csum_d = csum_q ^ byte_in;
                    if ((n_rx != 16'd0) && ({1'b0, n_rx} <= MAX_N)) begin
                        state_d = WORD_H;
                    end else begin
                        state_d = ERROR;
                        err_d   = ERR_LEN;
                    end
                end
            end
            WORD_H: begin
                if (xfer) begin
                    if (byte_in[7 -: OPC_W] > MAX_OPC) begin
                        state_d = ERROR;
                        err_d   = ERR_OPC;
                    end else begin
                        hi_d    = byte_in;
                        csum_d  = csum_q ^ byte_in;
                        state_d = WORD_L;
                    end
                end
            end
            WORD_L: begin
                if (xfer) begin
                    lo_d    = byte_in;
                    csum_d  = csum_q ^ byte_in;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wcount_d = wcount_q + 1'b1;
                // Saturate so the final increment of a full-memory load cannot wrap to 0.
                if (addr_q != '1) begin
                    addr_d = addr_q + 1'b1;
                end
                if ((17'(wcount_q) + 17'd1) < {1'b0, len_q}) begin
                    state_d = WORD_H;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (byte_in == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                        err_d   = ERR_SUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good loads (continuous and gapped), each error code, mid-session reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Writes and byte transfers are logged by monitors and compared against hand-computed values.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset_in;
    logic        start_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_ready_out;
    logic        imem_wr_out;
    logic [10:0] imem_addr_out;
    logic [15:0] imem_data_out;
    logic        cpu_reset_out;
    logic        busy_out;
    logic        done_out;
    logic [1:0]  error_out;
    logic [11:0] word_count_out;

    int n_cmp = 0;
    int n_bad = 0;
    int n_xfer;
    int rdy_in_write;
    logic [10:0] wr_addr[$];
    logic [15:0] wr_data[$];

    program_loader dut (
        .clock_in       (clk),
        .reset_in       (reset_in),
        .start_in       (start_in),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .byte_ready_out (byte_ready_out),
        .imem_wr_out    (imem_wr_out),
        .imem_addr_out  (imem_addr_out),
        .imem_data_out  (imem_data_out),
        .cpu_reset_out  (cpu_reset_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .error_out      (error_out),
        .word_count_out (word_count_out)
    );

    always #5 clk = ~clk;

    // Log every write strobe and every byte that will transfer on the coming edge.
    always @(negedge clk) begin
        if (imem_wr_out) begin
            wr_addr.push_back(imem_addr_out);
            wr_data.push_back(imem_data_out);
            if (byte_ready_out) rdy_in_write = 1;
        end
        if (byte_valid_in && byte_ready_out) n_xfer = n_xfer + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        n_xfer       = 0;
        rdy_in_write = 0;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; give up after a bounded wait.
    task automatic send_byte(input logic [7:0] b, input int gap, output int ok);
        int took;
        took = 0;
        byte_valid_in = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        byte_in       = b;
        byte_valid_in = 1'b1;
        for (int i = 0; i < 20 && took == 0; i++) begin
            @(negedge clk);
            took = byte_ready_out ? 1 : 0;
            @(posedge clk); #1;
        end
        byte_valid_in = 1'b0;
        ok = took;
    endtask

    task automatic send_stream(input logic [7:0] s[], input int gapped, input string tag);
        int ok;
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], gapped ? (i % 3) : 0, ok);
            if (ok == 0) begin
                check_eq({tag, "_byte_accept"}, 32'(i), 32'(s.size()));
                return;
            end
        end
    endtask

    task automatic wait_end(input string tag);
        int to;
        to = 1;
        for (int i = 0; i < 40 && to == 1; i++) begin
            @(negedge clk);
            if (done_out || error_out != 2'b00) to = 0;
        end
        check_eq({tag, "_timeout"}, 32'(to), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, 32'(byte_ready_out), 32'd0);
        check_eq({tag, "_wr"},    32'(imem_wr_out),    32'd0);
        check_eq({tag, "_addr"},  32'(imem_addr_out),  32'd0);
        check_eq({tag, "_data"},  32'(imem_data_out),  32'd0);
        check_eq({tag, "_cpurst"},32'(cpu_reset_out),  32'd0);
        check_eq({tag, "_busy"},  32'(busy_out),       32'd0);
        check_eq({tag, "_done"},  32'(done_out),       32'd0);
        check_eq({tag, "_err"},   32'(error_out),      32'd0);
        check_eq({tag, "_wcnt"},  32'(word_count_out), 32'd0);
    endtask

    task automatic good_load(input int gapped, input string tag);
        logic [7:0] s[];
        s = '{8'h00, 8'h02, 8'h18, 8'h05, 8'h00, 8'h00, 8'h1F};
        clear_logs();
        pulse_start();
        send_stream(s, gapped, tag);
        wait_end(tag);
        check_eq({tag, "_nwr"},   32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check_eq({tag, "_a0"}, 32'(wr_addr[0]), 32'h0);
            check_eq({tag, "_d0"}, 32'(wr_data[0]), 32'h1805);
            check_eq({tag, "_a1"}, 32'(wr_addr[1]), 32'h1);
            check_eq({tag, "_d1"}, 32'(wr_data[1]), 32'h0000);
        end
        check_eq({tag, "_xfers"},  32'(n_xfer),         32'd7);
        check_eq({tag, "_rdy_wr"}, 32'(rdy_in_write),   32'd0);
        check_eq({tag, "_wcnt"},   32'(word_count_out), 32'd2);
        check_eq({tag, "_done"},   32'(done_out),       32'd1);
        check_eq({tag, "_cpurst"}, 32'(cpu_reset_out),  32'd1);
        check_eq({tag, "_err"},    32'(error_out),      32'd0);
        check_eq({tag, "_busy"},   32'(busy_out),       32'd0);
    endtask

    initial begin
        logic [7:0] s[];
        reset_in      = 1'b1;
        start_in      = 1'b0;
        byte_in       = 8'h00;
        byte_valid_in = 1'b0;
        clear_logs();
        repeat (2) @(posedge clk);
        #1 reset_in = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        // Start pulse lands in LEN_H.
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        @(negedge clk);
        check_eq("start_busy",  32'(busy_out),       32'd1);
        check_eq("start_ready", 32'(byte_ready_out), 32'd1);
        @(posedge clk); #1;
        reset_in = 1'b1;
        @(posedge clk); #1;
        reset_in = 1'b0;

        good_load(0, "cont");
        // Hold in DONE across idle cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("done_hold", 32'(done_out), 32'd1);
        #1;
        good_load(1, "gap");

        // Illegal opcode in the first high byte.
        clear_logs();
        pulse_start();
        s = '{8'h00, 8'h01, 8'h80};
        send_stream(s, 0, "opc");
        wait_end("opc");
        check_eq("opc_err",    32'(error_out),       32'd2);
        check_eq("opc_nwr",    32'(wr_addr.size()),  32'd0);
        check_eq("opc_cpurst", 32'(cpu_reset_out),   32'd0);
        check_eq("opc_done",   32'(done_out),        32'd0);

        // Good word, bad checksum (expected 0x71).
        clear_logs();
        pulse_start();
        s = '{8'h00, 8'h01, 8'h70, 8'h00, 8'hFF};
        send_stream(s, 0, "sum");
        wait_end("sum");
        check_eq("sum_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check_eq("sum_a0", 32'(wr_addr[0]), 32'h0);
            check_eq("sum_d0", 32'(wr_data[0]), 32'h7000);
        end
        check_eq("sum_err",    32'(error_out),      32'd3);
        check_eq("sum_done",   32'(done_out),       32'd0);
        check_eq("sum_cpurst", 32'(cpu_reset_out),  32'd0);
        check_eq("sum_wcnt",   32'(word_count_out), 32'd1);

        // Zero length.
        clear_logs();
        pulse_start();
        s = '{8'h00, 8'h00};
        send_stream(s, 0, "len");
        wait_end("len");
        check_eq("len_err", 32'(error_out),      32'd1);
        check_eq("len_nwr", 32'(wr_addr.size()), 32'd0);
        check_eq("len_wcnt",32'(word_count_out), 32'd0);

        // Reset mid-session after the first word's high byte.
        clear_logs();
        pulse_start();
        s = '{8'h00, 8'h01, 8'h70};
        send_stream(s, 0, "mid");
        @(negedge clk);
        check_eq("mid_busy_pre", 32'(busy_out), 32'd1);
        #1;
        reset_in = 1'b1;
        byte_in = 8'h00;
        byte_valid_in = 1'b1;
        @(posedge clk); #1;
        reset_in = 1'b0;
        byte_valid_in = 1'b0;
        @(negedge clk);
        check_reset_vals("mid");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("mid_nwr", 32'(wr_addr.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 11: operand field width of an instruction word.
REQ-002 Parameter INSTRUCTION_WIDTH, default 15: MSB index of an instruction word, so a word is INSTRUCTION_WIDTH+1 = 16 bits and the opcode is bits [15:11], 5 bits.
REQ-003 Parameter ADDR_WIDTH, default 11: instruction-memory address width.
REQ-004 Port clock_in, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port reset_in, input, 1 bit: reset is synchronous and active-high.
REQ-006 Port start_in, input, 1 bit: starts a load session when sampled high in IDLE, DONE or ERROR.
REQ-007 Port byte_in, input, 8 bits: serial program byte.
REQ-008 Port byte_valid_in, input, 1 bit: byte_in holds a valid byte.
REQ-009 Port byte_ready_out, output, 1 bit: the loader accepts byte_in this cycle.
REQ-010 Port imem_wr_out, output, 1 bit: instruction-memory write strobe.
REQ-011 Port imem_addr_out, output, ADDR_WIDTH bits: write address.
REQ-012 Port imem_data_out, output, INSTRUCTION_WIDTH+1 bits: write data.
REQ-013 Port cpu_reset_out, output, 1 bit, active-low: CPU reset, driven low while no verified program is loaded.
REQ-014 Port busy_out, output, 1 bit: a session is in progress.
REQ-015 Port done_out, output, 1 bit: the last session completed successfully.
REQ-016 Port error_out, output, 2 bits: 00 none, 01 bad length, 10 illegal opcode, 11 checksum mismatch.
REQ-017 Port word_count_out, output, ADDR_WIDTH+1 bits: number of words written in the current or last session.

Function
REQ-018 The byte stream SHALL be: count high byte, count low byte, then N words each sent high byte first, then one checksum byte.
REQ-019 A byte SHALL transfer on a rising edge where byte_valid_in && byte_ready_out; no other byte SHALL be consumed.
REQ-020 The FSM states SHALL be IDLE, LEN_H, LEN_L, WORD_H, WORD_L, WRITE, CHECK, DONE and ERROR.
REQ-021 byte_ready_out SHALL be 1 only in LEN_H, LEN_L, WORD_H, WORD_L and CHECK.
REQ-022 FSM transitions:
- IDLE, DONE or ERROR with start_in=1 -> LEN_H; this clears word_count_out, the address counter, the checksum accumulator and error_out.
- On a transfer: LEN_H -> LEN_L, LEN_L -> WORD_H, WORD_H -> WORD_L, WORD_L -> WRITE.
- WRITE -> WORD_H if words written < N, otherwise WRITE -> CHECK.
- CHECK with a transfer -> DONE.
REQ-023 start_in SHALL be ignored in LEN_H through CHECK.
REQ-024 N is the 16-bit header value; a legal N satisfies 1 <= N <= 2^ADDR_WIDTH; an illegal N on the LEN_L transfer SHALL go to ERROR with code 01.
REQ-025 On the WORD_H transfer, opcode byte_in[7:3] > 5'b01110 SHALL go to ERROR with code 10, and that word SHALL NOT be written.
REQ-026 In WRITE, imem_wr_out SHALL be 1 for exactly that one cycle, with imem_data_out = {high byte, low byte} and imem_addr_out = the current address.
REQ-027 In WRITE, the address and word_count_out SHALL increment on leaving WRITE; the address starts at 0 and never wraps within a session.
REQ-028 The checksum accumulator SHALL XOR every transferred byte from count high through the last word low byte.
REQ-029 On the CHECK transfer, byte_in equal to the accumulator -> DONE; otherwise -> ERROR with code 11.
REQ-030 imem_wr_out SHALL be 0 in every state except WRITE.
REQ-031 busy_out SHALL be 1 in LEN_H through CHECK.
REQ-032 done_out SHALL be 1 only in DONE.
REQ-033 cpu_reset_out SHALL be 1 only in DONE; words already written during a failed session stay in memory, and the CPU stays in reset.
REQ-034 DONE and ERROR SHALL hold their outputs until start_in or reset_in.

Reset
REQ-035 reset_in=1 at a rising edge SHALL force IDLE and clear all counters, checksum and error_out, with priority over start_in and any transfer, including mid-session.
REQ-036 Reset values SHALL be: byte_ready_out 0, imem_wr_out 0, imem_addr_out 0, imem_data_out 0, cpu_reset_out 0, busy_out 0, done_out 0, error_out 00, word_count_out 0.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Reset -> all outputs at REQ-036 values; start_in pulse -> LEN_H, busy_out=1, byte_ready_out=1.
- Bytes 00 02 18 05 00 00 1F, valid continuous -> writes addr0=0x1805 and addr1=0x0000, one cycle each; word_count_out=2; done_out=1; cpu_reset_out=1; error_out=00.
- Same stream with byte_valid_in gaps and valid held during WRITE -> identical writes; no byte lost or duplicated; byte_ready_out=0 in WRITE.
- Bytes 00 01 80 -> ERROR, error_out=10, no imem_wr_out pulse, cpu_reset_out=0.
- Bytes 00 01 70 00 FF -> one write of 0x7000 at addr 0, then error_out=11, done_out=0.
- Bytes 00 00 -> error_out=01.
- reset_in asserted after the first word high byte -> IDLE next cycle, no write, all outputs at reset values.
